// File: rtl/mutil_acc_unit.sv
// Pipelined multiply / multiply-accumulate unit with saturating group sums.
// Beats pass an input capture register plus PIPE_DEPTH delay stages, then a registered result.
module mutil_acc_unit #(
    parameter int DATA_W     = 8,
    parameter int PSUM_W     = 32,
    parameter int PIPE_DEPTH = 4,
    parameter bit SIGNED     = 1'b1
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              acc_mode,
    input  logic              first,
    input  logic              last,
    output logic [PSUM_W-1:0] rlst,
    output logic              rlst_vld,
    output logic              sat_flag
);

    localparam int STAGES  = PIPE_DEPTH + 1;
    localparam int OUT_IDX = STAGES - 1;
    localparam logic [PSUM_W-1:0] MAX_S = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] MIN_S = {1'b1, {(PSUM_W-1){1'b0}}};

    typedef struct packed {
        logic              acc_mode;
        logic              first;
        logic              last;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } beat_t;

    logic [STAGES-1:0] vld_q, vld_d;
    beat_t             beat_q [STAGES];
    beat_t             beat_d [STAGES];

    logic [PSUM_W-1:0] rlst_q, rlst_d;
    logic              rlst_vld_q, rlst_vld_d;
    logic              sat_q, sat_d;
    logic [PSUM_W-1:0] acc_q, acc_d;
    logic              grp_sat_q, grp_sat_d;

    always_comb begin
        vld_d     = {vld_q[STAGES-2:0], valid};
        beat_d[0] = '{acc_mode: acc_mode, first: first, last: last, a: a, b: b};
        for (int i = 1; i < STAGES; i++) begin
            beat_d[i] = beat_q[i-1];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // NOTE: operand/tag stages are left unreset; the valid bits alone decide whether a stage holds a beat.
    always_ff @(posedge s_clk) begin
        for (int i = 0; i < STAGES; i++) begin
            beat_q[i] <= beat_d[i];
        end
    end

    beat_t             out_beat;
    logic [PSUM_W-1:0] a_ext, b_ext, prod, base, clamped;
    logic [PSUM_W:0]   sum;
    logic              clamp;

    assign out_beat = beat_q[OUT_IDX];

    // Extending before the multiply keeps the low PSUM_W bits equal to the extended full product.
    always_comb begin
        a_ext = {{(PSUM_W-DATA_W){SIGNED & out_beat.a[DATA_W-1]}}, out_beat.a};
        b_ext = {{(PSUM_W-DATA_W){SIGNED & out_beat.b[DATA_W-1]}}, out_beat.b};
        prod  = a_ext * b_ext;
        base  = out_beat.first ? '0 : acc_q;
        sum   = {SIGNED & base[PSUM_W-1], base} + {SIGNED & prod[PSUM_W-1], prod};
        if (SIGNED) begin
            clamp   = sum[PSUM_W] ^ sum[PSUM_W-1];
            clamped = clamp ? (sum[PSUM_W] ? MIN_S : MAX_S) : sum[PSUM_W-1:0];
        end else begin
            clamp   = sum[PSUM_W];
            clamped = clamp ? '1 : sum[PSUM_W-1:0];
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        rlst_d     = rlst_q;
        rlst_vld_d = 1'b0;
        sat_d      = sat_q;
        acc_d      = acc_q;
        grp_sat_d  = grp_sat_q;
        if (vld_q[OUT_IDX]) begin
            if (!out_beat.acc_mode) begin
                rlst_d     = prod;
                sat_d      = 1'b0;
                rlst_vld_d = 1'b1;
            end else begin
                grp_sat_d = (out_beat.first ? 1'b0 : grp_sat_q) | clamp;
                if (out_beat.last) begin
                    rlst_d     = clamped;
                    sat_d      = grp_sat_d;
                    rlst_vld_d = 1'b1;
                    acc_d      = '0;
                    grp_sat_d  = 1'b0;
                end else begin
                    acc_d = clamped;
                end
            end
        end
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            rlst_q     <= '0;
            rlst_vld_q <= 1'b0;
            sat_q      <= 1'b0;
            acc_q      <= '0;
            grp_sat_q  <= 1'b0;
        end else begin
            rlst_q     <= rlst_d;
            rlst_vld_q <= rlst_vld_d;
            sat_q      <= sat_d;
            acc_q      <= acc_d;
            grp_sat_q  <= grp_sat_d;
        end
    end

    assign rlst     = rlst_q;
    assign rlst_vld = rlst_vld_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_mutil_acc_unit.sv
// Directed + short random stimulus for mutil_acc_unit; a behavioural model fills a scoreboard
// at drive time and each output pulse is popped and compared on the cycle it is due.
module tb_mutil_acc_unit;

    localparam int DATA_W     = 8;
    localparam int PSUM_W     = 16;
    localparam int PIPE_DEPTH = 4;
    localparam int LAT        = PIPE_DEPTH + 1;

    logic              s_clk = 1'b0;
    logic              s_rst = 1'b1;
    logic              valid = 1'b0;
    logic [DATA_W-1:0] a = '0;
    logic [DATA_W-1:0] b = '0;
    logic              acc_mode = 1'b0;
    logic              first = 1'b0;
    logic              last = 1'b0;
    logic [PSUM_W-1:0] rlst;
    logic              rlst_vld;
    logic              sat_flag;

    typedef struct {
        int              due;
        logic [PSUM_W-1:0] res;
        logic            sat;
    } exp_t;

    exp_t        sb[$];
    logic [16:0] obs_q[$];
    int          checks = 0;
    int          failures = 0;
    int          edge_cnt = 0;
    int          m_acc = 0;
    bit          m_gsat = 1'b0;
    logic [PSUM_W-1:0] m_rlst = '0;
    logic        m_sat = 1'b0;

    mutil_acc_unit #(
        .DATA_W(DATA_W), .PSUM_W(PSUM_W), .PIPE_DEPTH(PIPE_DEPTH), .SIGNED(1'b1)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .valid(valid), .a(a), .b(b),
        .acc_mode(acc_mode), .first(first), .last(last),
        .rlst(rlst), .rlst_vld(rlst_vld), .sat_flag(sat_flag)
    );

    always #5 s_clk = ~s_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: sample outputs 1ns after the rising edge and compare against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge s_clk);
        edge_cnt++;
        #1;
        if (!s_rst) begin
            check("rst_rlst", rlst, 0);
            check("rst_vld", rlst_vld, 0);
            check("rst_sat", sat_flag, 0);
        end else if (rlst_vld) begin
            if (sb.size() == 0) begin
                check("spurious_vld", rlst_vld, 0);
            end else begin
                e = sb.pop_front();
                check("vld_timing", edge_cnt, e.due);
                check("rlst", rlst, e.res);
                check("sat_flag", sat_flag, e.sat);
                m_rlst = e.res;
                m_sat  = e.sat;
                obs_q.push_back({sat_flag, rlst});
            end
        end else begin
            if (sb.size() > 0) check("vld_missing", sb[0].due <= edge_cnt, 0);
            check("rlst_hold", rlst, m_rlst);
            check("sat_hold", sat_flag, m_sat);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] av, input logic [7:0] bv,
                         input bit mode, input bit f, input bit l);
        int p, s;
        bit gs;
        valid = v; a = av; b = bv; acc_mode = mode; first = f; last = l;
        if (v) begin
            p = $signed(av) * $signed(bv);
            if (!mode) begin
                sb.push_back('{due: edge_cnt + 1 + LAT, res: p[15:0], sat: 1'b0});
            end else begin
                s  = (f ? 0 : m_acc) + p;
                gs = f ? 1'b0 : m_gsat;
                if (s > 32767) begin s = 32767; gs = 1'b1; end
                else if (s < -32768) begin s = -32768; gs = 1'b1; end
                if (l) begin
                    sb.push_back('{due: edge_cnt + 1 + LAT, res: s[15:0], sat: gs});
                    m_acc = 0; m_gsat = 1'b0;
                end else begin
                    m_acc = s; m_gsat = gs;
                end
            end
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_obs(input string tag, input logic [15:0] r, input logic s);
        logic [16:0] o;
        check({tag, "_present"}, obs_q.size() > 0, 1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check({tag, "_rlst"}, o[15:0], r);
            check({tag, "_sat"}, o[16], s);
        end
    endtask

    initial begin
        #2 s_rst = 1'b0;
        // Reset held for 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            acc_mode = 1'($urandom); first = 1'($urandom); last = 1'($urandom);
            tick();
        end
        s_rst = 1'b1;
        idle(LAT + 2);

        // Single product, pulse exactly LAT edges later.
        drive(1'b1, 8'hFD, 8'h07, 1'b0, 1'b0, 1'b0);
        idle(LAT + 2);
        expect_obs("single", 16'hFFEB, 1'b0);
        check("single_one_pulse", obs_q.size(), 0);

        // Streaming group followed immediately by a one-beat group.
        drive(1'b1, 8'd2, 8'd3, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'd4, 8'd5, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 8'd6, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b1);
        idle(LAT + 2);
        expect_obs("stream_g1", 16'h0014, 1'b0);
        expect_obs("stream_g2", 16'h0001, 1'b0);

        // Saturating group then a clean group.
        drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'd127, 8'd127, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b1);
        idle(LAT + 2);
        expect_obs("sat_group", 16'h7FFF, 1'b1);
        expect_obs("sat_clear", 16'h0001, 1'b0);

        // Negative saturation.
        drive(1'b1, 8'h80, 8'd127, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'h80, 8'd127, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h80, 8'd127, 1'b1, 1'b0, 1'b1);
        idle(LAT + 2);
        expect_obs("neg_sat", 16'h8000, 1'b1);

        // Mode 0 beat inside an open group; first/last ignored in mode 0.
        drive(1'b1, 8'd3, 8'd3, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'd2, 8'd2, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'd1, 8'd1, 1'b1, 1'b0, 1'b1);
        idle(LAT + 2);
        expect_obs("interleave_m0", 16'h0004, 1'b0);
        expect_obs("interleave_grp", 16'h000A, 1'b0);

        // Reset while three beats are in flight.
        drive(1'b1, 8'd10, 8'd10, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'd10, 8'd10, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'd10, 8'd10, 1'b1, 1'b0, 1'b1);
        idle(1);
        s_rst = 1'b0;
        sb.delete();
        m_acc = 0; m_gsat = 1'b0; m_rlst = '0; m_sat = 1'b0;
        tick();
        s_rst = 1'b1;
        idle(LAT + 3);
        check("flush_no_output", obs_q.size(), 0);
        drive(1'b1, 8'd5, 8'd5, 1'b1, 1'b0, 1'b1);
        idle(LAT + 2);
        expect_obs("post_reset", 16'h0019, 1'b0);

        // Short random mix checked against the model.
        for (int i = 0; i < 120; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 4) == 0));
        end
        idle(LAT + 2);
        check("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
